// File: rtl/sfp_sqrt_seq.sv
// rtl/sfp_sqrt_seq.sv - iterative floor(sqrt) of a signed Q(IW.QW) value, one root bit per cycle
// Restoring digit-by-digit square root with a valid/ready handshake and one operation in flight.
module sfp_sqrt_seq #(
  parameter int IW = 16,
  parameter int QW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IW+QW-1:0]  in_val,
  input  logic              in_clipping,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IW+QW-1:0]  out_val,
  output logic              out_neg,
  output logic              out_clipping
);

  localparam int W  = IW + QW;
  localparam int RW = IW + 2 * QW;
  localparam int N  = RW / 2;
  localparam int CW = $clog2(N + 1);

  if ((RW % 2) != 0) begin : g_bad_width
    $error("sfp_sqrt_seq: IW+2*QW must be even");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   rad_q, rad_d;
  logic [N+1:0]    rem_q, rem_d;
  logic [N-1:0]    root_q, root_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    out_val_q, out_val_d;
  logic            out_neg_q, out_neg_d;
  logic            out_clip_q, out_clip_d;
  logic            out_valid_q, out_valid_d;

  logic [N+1:0]    rem_sh;
  logic [N+1:0]    trial;
  logic            fits;

  // The remainder never exceeds 2*root, so the bits shifted out of the top are always zero.
  assign rem_sh = (N+2)'({rem_q, rad_q[RW-1 -: 2]});
  assign trial  = {root_q, 2'b01};
  assign fits   = (rem_sh >= trial);

  always_comb begin
    state_d     = state_q;
    rad_d       = rad_q;
    rem_d       = rem_q;
    root_d      = root_q;
    cnt_d       = cnt_q;
    out_val_d   = out_val_q;
    out_neg_d   = out_neg_q;
    out_clip_d  = out_clip_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          out_clip_d = in_clipping;
          if (in_val[W-1]) begin
            out_val_d = '0;
            out_neg_d = 1'b1;
            state_d   = DONE;
          end else begin
            rad_d   = {in_val, {QW{1'b0}}};
            rem_d   = '0;
            root_d  = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rad_d  = rad_q << 2;
        rem_d  = fits ? (rem_sh - trial) : rem_sh;
        root_d = N'({root_q, fits});
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          out_val_d   = {{(W-N){1'b0}}, root_d};
          out_neg_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // A negative operand arrives here with out_valid low; it rises one edge later.
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      out_val_q   <= '0;
      out_neg_q   <= 1'b0;
      out_clip_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rad_q       <= rad_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      cnt_q       <= cnt_d;
      out_val_q   <= out_val_d;
      out_neg_q   <= out_neg_d;
      out_clip_q  <= out_clip_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = out_valid_q;
  assign out_val      = out_val_q;
  assign out_neg      = out_neg_q;
  assign out_clipping = out_clip_q;

endmodule

// File: tb/tb_sfp_sqrt_seq.sv
// tb/tb_sfp_sqrt_seq.sv - self-checking bench for sfp_sqrt_seq against an integer sqrt model
module tb_sfp_sqrt_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_val;
  logic        in_clipping;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_val;
  logic        out_neg;
  logic        out_clipping;

  int checks;
  int errors;

  sfp_sqrt_seq #(.IW(16), .QW(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_val       (in_val),
    .in_clipping  (in_clipping),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_val      (out_val),
    .out_neg      (out_neg),
    .out_clipping (out_clipping)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // floor(sqrt(x * 2^16)) by binary search; negative operands map to 0
  function automatic logic [31:0] ref_sqrt(input logic [31:0] x);
    longint unsigned v, lo, hi, mid;
    if (x[31]) return 32'h0;
    v  = longint'(x) * 65536;
    lo = 0;
    hi = 64'd16777216;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid;
    end
    return 32'(lo);
  endfunction

  task automatic drive_op(input logic [31:0] v, input logic clip, input int hold,
                          output logic [31:0] rv, output logic rn, output logic rc,
                          output int lat, output logic ready_leak, output logic unstable);
    int k;
    k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    in_valid    = 1'b1;
    in_val      = v;
    in_clipping = clip;
    @(posedge clk); #1;
    in_valid    = 1'($urandom);
    in_val      = $urandom;
    in_clipping = 1'($urandom);
    lat = 0;
    ready_leak = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_leak = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    rv = out_val;
    rn = out_neg;
    rc = out_clipping;
    unstable = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (out_val !== rv || out_neg !== rn || out_clipping !== rc ||
          out_valid !== 1'b1 || in_ready !== 1'b0) unstable = 1'b1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_val !== 32'h0 || out_neg !== 1'b0 ||
        out_clipping !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%b val=%h neg=%b clip=%b ready=%b, required 0 0 0 0 1",
               out_valid, out_val, out_neg, out_clipping, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] rv; logic rn, rc, leak, unst; int lat;
    drive_op(32'h0004_0000, 1'b0, 0, rv, rn, rc, lat, leak, unst);
    checks++;
    if (rv !== 32'h0002_0000 || rn !== 1'b0 || rc !== 1'b0) begin
      errors++;
      $display("FAIL sqrt4: val=%h neg=%b clip=%b, required 00020000 0 0", rv, rn, rc);
    end
    checks++;
    if (lat !== 24) begin
      errors++;
      $display("FAIL sqrt4_latency: %0d edges, required 24", lat);
    end
    checks++;
    if (leak !== 1'b0) begin
      errors++;
      $display("FAIL sqrt4_busy_ready: in_ready seen high while busy");
    end
  endtask

  task automatic test_small();
    logic [31:0] vin [3];
    logic [31:0] vexp [3];
    logic [31:0] rv; logic rn, rc, leak, unst; int lat;
    vin[0] = 32'h0002_0000; vexp[0] = 32'h0001_6A09;
    vin[1] = 32'h0000_0001; vexp[1] = 32'h0000_0100;
    vin[2] = 32'h0000_0000; vexp[2] = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      drive_op(vin[i], 1'b0, 0, rv, rn, rc, lat, leak, unst);
      checks++;
      if (rv !== vexp[i] || rn !== 1'b0 || lat !== 24) begin
        errors++;
        $display("FAIL small[%0d]: in=%h val=%h neg=%b lat=%0d, required %h 0 24",
                 i, vin[i], rv, rn, lat, vexp[i]);
      end
    end
  endtask

  task automatic test_max_clip();
    logic [31:0] rv; logic rn, rc, leak, unst; int lat;
    drive_op(32'h7FFF_FFFF, 1'b1, 0, rv, rn, rc, lat, leak, unst);
    checks++;
    if (rv !== 32'h00B5_04F3 || rn !== 1'b0 || rc !== 1'b1) begin
      errors++;
      $display("FAIL max_clip: val=%h neg=%b clip=%b, required 00b504f3 0 1", rv, rn, rc);
    end
  endtask

  task automatic test_negative();
    logic [31:0] rv, v; logic rn, rc, leak, unst; int lat;
    drive_op(32'hFFFF_0000, 1'b0, 0, rv, rn, rc, lat, leak, unst);
    checks++;
    if (rv !== 32'h0 || rn !== 1'b1 || lat !== 1 || leak !== 1'b0) begin
      errors++;
      $display("FAIL neg_one: val=%h neg=%b lat=%0d leak=%b, required 0 1 1 0", rv, rn, lat, leak);
    end
    for (int i = 0; i < 8; i++) begin
      v = $urandom | 32'h8000_0000;
      drive_op(v, 1'(i), 0, rv, rn, rc, lat, leak, unst);
      checks++;
      if (rv !== 32'h0 || rn !== 1'b1 || rc !== 1'(i) || lat !== 1) begin
        errors++;
        $display("FAIL neg_rand: in=%h val=%h neg=%b clip=%b lat=%0d, required 0 1 %b 1",
                 v, rv, rn, rc, lat, 1'(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rv; logic rn, rc, leak, unst; int lat;
    drive_op(32'h0019_0000, 1'b1, 10, rv, rn, rc, lat, leak, unst);
    checks++;
    if (rv !== 32'h0005_0000 || rc !== 1'b1 || unst !== 1'b0) begin
      errors++;
      $display("FAIL hold: val=%h clip=%b unstable=%b, required 00050000 1 0", rv, rc, unst);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_transfer: ready=%b valid=%b, required 1 0", in_ready, out_valid);
    end
    drive_op(32'h0010_0000, 1'b0, 0, rv, rn, rc, lat, leak, unst);
    checks++;
    if (rv !== 32'h0004_0000 || rn !== 1'b0 || rc !== 1'b0 || lat !== 24) begin
      errors++;
      $display("FAIL back_to_back: val=%h neg=%b clip=%b lat=%0d, required 00040000 0 0 24",
               rv, rn, rc, lat);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] rv; logic rn, rc, leak, unst; int lat;
    logic seen;
    in_valid    = 1'b1;
    in_val      = 32'h0004_0000;
    in_clipping = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_clipping !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b ready=%b clip=%b, required 0 1 0",
               out_valid, in_ready, out_clipping);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL discarded: out_valid seen after reset, required none");
    end
    drive_op(32'h0009_0000, 1'b0, 0, rv, rn, rc, lat, leak, unst);
    checks++;
    if (rv !== 32'h0003_0000 || rn !== 1'b0) begin
      errors++;
      $display("FAIL sqrt9: val=%h neg=%b, required 00030000 0", rv, rn);
    end
  endtask

  task automatic test_random();
    logic [31:0] rv, v, exp_v; logic rn, rc, leak, unst, clip; int lat;
    for (int i = 0; i < 1000; i++) begin
      v = ($urandom & 32'h7FFF_FFFF) >> $urandom_range(0, 31);
      clip = 1'($urandom);
      exp_v = ref_sqrt(v);
      drive_op(v, clip, $urandom_range(0, 2), rv, rn, rc, lat, leak, unst);
      checks++;
      if (rv !== exp_v || rn !== 1'b0 || rc !== clip || lat !== 24 || leak || unst) begin
        errors++;
        $display("FAIL random[%0d]: in=%h val=%h neg=%b clip=%b lat=%0d, required %h 0 %b 24",
                 i, v, rv, rn, rc, lat, exp_v, clip);
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_val      = 32'h0;
    in_clipping = 1'b0;
    out_ready   = 1'b0;
    test_reset();
    test_basic();
    test_small();
    test_max_clip();
    test_negative();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
